elevator_motion_fsm: RTL

- Sequential controller downstream of the button register and control-button decode stages.
- Consumes the relative request vectors ctrl_button_up/down/in, which are indexed [0] here, [1] above, [2] below, relative to the current floor.
- Produces car position, door-open and direction.
- Its pos/open outputs feed back to the button register, which clears a floor's request while the door is open there, and to the control-button decode.

---
 rtl/elevator_pkg.sv | 37 +++
 rtl/elevator_motion_fsm_cycle_timer.sv | 27 ++
 rtl/elevator_motion_fsm.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator datapath: FSM states, floor codes and
// relative request indexing used by the button decode and the motion FSM.
package elevator_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MOVE_UP   = 3'd1;
  localparam logic [2:0] ST_MOVE_DOWN = 3'd2;
  localparam logic [2:0] ST_ARRIVE    = 3'd3;
  localparam logic [2:0] ST_DOOR_OPEN = 3'd4;

  localparam logic [1:0] FLOOR1 = 2'd0;
  localparam logic [1:0] FLOOR2 = 2'd1;
  localparam logic [1:0] FLOOR3 = 2'd2;
  localparam logic [1:0] FLOOR4 = 2'd3;

  // Request vectors are relative to the car: [0] here, [1] above, [2] below.
  localparam int IDX_HERE  = 0;
  localparam int IDX_ABOVE = 1;
  localparam int IDX_BELOW = 2;

  typedef struct packed {
    logic here;
    logic above;
    logic below;
  } req_groups_t;

  function automatic req_groups_t group_requests(input logic [2:0] up,
                                                 input logic [2:0] down,
                                                 input logic [2:0] in_car);
    req_groups_t g;
    g.here  = up[IDX_HERE]  | down[IDX_HERE]  | in_car[IDX_HERE];
    g.above = up[IDX_ABOVE] | down[IDX_ABOVE] | in_car[IDX_ABOVE];
    g.below = up[IDX_BELOW] | down[IDX_BELOW] | in_car[IDX_BELOW];
    return g;
  endfunction

endpackage

// File: rtl/elevator_motion_fsm_cycle_timer.sv
// Loadable down-counter shared by travel and door timing; done marks the
// last counted cycle (count of one, or an idle zero).
module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count <= W'(1));

endmodule

// File: rtl/elevator_motion_fsm.sv
// Car motion controller: picks a travel direction from relative requests,
// times floor-to-floor moves and door dwell, and reports position/door state.
module elevator_motion_fsm
  import elevator_pkg::*;
#(
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ctrl_button_up,
  input  logic [2:0] ctrl_button_down,
  input  logic [2:0] ctrl_button_in,
  input  logic       door_hold,
  output logic [1:0] pos,
  output logic       open,
  output logic       dir_up,
  output logic       moving
);

  localparam int TIMER_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [1:0]    next_pos;
  logic          next_dir;
  logic          hold_reload;
  logic          timer_load;
  logic          timer_done;
  logic [TW-1:0] timer_val;
  req_groups_t   req;
  logic          stop;
  logic          pref;
  logic          opp;
  logic [2:0]    cont_state;
  logic          cont_dir;

  assign req = group_requests(ctrl_button_up, ctrl_button_down, ctrl_button_in);

  // A call in the travel direction is picked up on the way; a call the other
  // way is only taken when nothing lies further ahead of the car.
  assign stop = dir_up
    ? (ctrl_button_in[IDX_HERE] | ctrl_button_up[IDX_HERE]   | (ctrl_button_down[IDX_HERE] & ~req.above))
    : (ctrl_button_in[IDX_HERE] | ctrl_button_down[IDX_HERE] | (ctrl_button_up[IDX_HERE]   & ~req.below));

  // Where to head after an arrival without a stop or after the door closes.
  always_comb begin
    pref       = dir_up ? req.above : req.below;
    opp        = dir_up ? req.below : req.above;
    cont_state = ST_IDLE;
    cont_dir   = dir_up;
    if (pref) begin
      cont_state = dir_up ? ST_MOVE_UP : ST_MOVE_DOWN;
    end else if (opp) begin
      cont_state = dir_up ? ST_MOVE_DOWN : ST_MOVE_UP;
      cont_dir   = ~dir_up;
    end
  end

  always_comb begin
    next_state  = state;
    next_pos    = pos;
    next_dir    = dir_up;
    hold_reload = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req.here) begin
          next_state = ST_DOOR_OPEN;
        end else if (req.above) begin
          next_state = ST_MOVE_UP;
          next_dir   = 1'b1;
        end else if (req.below) begin
          next_state = ST_MOVE_DOWN;
          next_dir   = 1'b0;
        end
      end
      ST_MOVE_UP: begin
        if (timer_done) begin
          next_state = ST_ARRIVE;
          if (pos != FLOOR4) next_pos = pos + 2'd1;
        end
      end
      ST_MOVE_DOWN: begin
        if (timer_done) begin
          next_state = ST_ARRIVE;
          if (pos != FLOOR1) next_pos = pos - 2'd1;
        end
      end
      ST_ARRIVE: begin
        if (stop) begin
          next_state = ST_DOOR_OPEN;
        end else begin
          next_state = cont_state;
          next_dir   = cont_dir;
        end
      end
      ST_DOOR_OPEN: begin
        if (door_hold) begin
          hold_reload = 1'b1;
        end else if (timer_done) begin
          next_state = cont_state;
          next_dir   = cont_dir;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The timer is reloaded on every state entry and on each held door cycle.
  assign timer_load = hold_reload | (next_state != state);

  always_comb begin
    timer_val = '0;
    if (next_state == ST_MOVE_UP || next_state == ST_MOVE_DOWN) begin
      timer_val = MOVE_LOAD;
    end else if (next_state == ST_DOOR_OPEN) begin
      timer_val = DOOR_LOAD;
    end
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      pos    <= FLOOR1;
      dir_up <= 1'b1;
      open   <= 1'b0;
      moving <= 1'b0;
    end else begin
      state  <= next_state;
      pos    <= next_pos;
      dir_up <= next_dir;
      open   <= (next_state == ST_DOOR_OPEN);
      moving <= (next_state == ST_MOVE_UP) || (next_state == ST_MOVE_DOWN);
    end
  end

endmodule
